// File: rtl/fb_pixel_writer_pkg.sv
// Shared types and constants for the frame-buffer pixel writer.
// Screen geometry, tuple field widths, the buffered pixel tuple and the FSM states.
package fb_pixel_writer_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int FB_ADDR_W = 17;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int COLOUR_W  = 3;

  // Clip limits sized to the coordinate fields so comparisons stay width-matched
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                last;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous FIFO of pixel tuples with registered count, full and empty flags.
module fb_pixel_fifo
  import fb_pixel_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  pixel_t                   data_i,
  output pixel_t                   data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             doPush, doPop;

  assign doPush  = push_i && !full_q;
  assign doPop   = pop_i && !empty_q;
  assign count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);

  // Storage needs no reset; only pointers and flags define validity
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers sprite pixel tuples, clips to the screen and issues frame-buffer writes.
// Define TRANSPARENT_SKIP_EN to suppress writes of TRANSPARENT_COLOUR pixels.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH         = 4,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 3'b101
) (
  input  logic                 clock_all,
  input  logic                 reset_all,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_W-1:0]       in_x,
  input  logic [Y_W-1:0]       in_y,
  input  logic [COLOUR_W-1:0]  in_colour,
  input  logic                 in_last,
  input  logic                 fb_hold,
  output logic                 fb_wren,
  output logic [FB_ADDR_W-1:0] fb_address,
  output logic [COLOUR_W-1:0]  fb_data,
  output logic                 sprite_done,
  output logic                 busy,
  output logic [15:0]          clip_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef TRANSPARENT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  state_t               state_q, state_d;
  pixel_t               inPix, headPix;
  logic                 push, pop, fifoFull, fifoEmpty;
  logic [CNT_W-1:0]     fifoCount, countNext;
  logic                 inReady_q, fbWren_q, lastRetired_q;
  logic [FB_ADDR_W-1:0] fbAddress_q;
  logic [COLOUR_W-1:0]  fbData_q;
  logic [15:0]          clipCount_q;
  logic                 onScreen, transparent, doWrite;

  assign inPix       = '{x: in_x, y: in_y, colour: in_colour, last: in_last};
  assign push        = in_valid && inReady_q && !fifoFull;
  assign pop         = !fifoEmpty && !fb_hold;
  assign countNext   = fifoCount + CNT_W'(push) - CNT_W'(pop);
  assign onScreen    = (headPix.x < X_LIM) && (headPix.y < Y_LIM);
  assign transparent = SKIP_EN && (headPix.colour == TRANSPARENT_COLOUR);
  assign doWrite     = pop && onScreen && !transparent;

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clock_all),
    .rst_ni  (reset_all),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (inPix),
    .data_o  (headPix),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // in_ready looks at the post-edge count so a pop on a full FIFO cannot admit a push that cycle
  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      inReady_q     <= 1'b0;
      fbWren_q      <= 1'b0;
      fbAddress_q   <= '0;
      fbData_q      <= '0;
      clipCount_q   <= '0;
      lastRetired_q <= 1'b0;
    end else begin
      inReady_q     <= (countNext < CNT_W'(FIFO_DEPTH));
      fbWren_q      <= doWrite;
      lastRetired_q <= pop && headPix.last;
      if (doWrite) begin
        fbAddress_q <= FB_ADDR_W'({headPix.y, 8'b0}) + FB_ADDR_W'({headPix.y, 6'b0})
                     + FB_ADDR_W'(headPix.x);
        fbData_q    <= headPix.colour;
      end
      if (pop && !onScreen && (clipCount_q != 16'hFFFF)) clipCount_q <= clipCount_q + 16'd1;
    end
  end

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // DONE follows the write cycle of a last tuple; back-to-back lasts keep it for another pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifoEmpty || push) state_d = STREAM;
      STREAM:  if (lastRetired_q) state_d = DONE;
      DONE: begin
        if (lastRetired_q)           state_d = DONE;
        else if (fifoEmpty && !push) state_d = IDLE;
        else                         state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sprite_done = 1'b0;
    busy        = !fifoEmpty;
    if (state_q == DONE) sprite_done = 1'b1;
    if (state_q != IDLE) busy = 1'b1;
  end

  assign in_ready   = inReady_q;
  assign fb_wren    = fbWren_q;
  assign fb_address = fbAddress_q;
  assign fb_data    = fbData_q;
  assign clip_count = clipCount_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the pixel writer.
module tb_fb_pixel_writer;

  localparam int DEPTH = 4;
`ifdef TRANSPARENT_SKIP_EN
  localparam bit TB_SKIP = 1'b1;
`else
  localparam bit TB_SKIP = 1'b0;
`endif

  logic        clock_all = 1'b0;
  logic        reset_all = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        fb_hold   = 1'b0;
  logic [8:0]  in_x      = '0;
  logic [7:0]  in_y      = '0;
  logic [2:0]  in_colour = '0;
  logic        in_ready, fb_wren, sprite_done, busy;
  logic [16:0] fb_address;
  logic [2:0]  fb_data;
  logic [15:0] clip_count;

  always #5 clock_all = ~clock_all;

  fb_pixel_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock_all   (clock_all),
    .reset_all   (reset_all),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .in_last     (in_last),
    .fb_hold     (fb_hold),
    .fb_wren     (fb_wren),
    .fb_address  (fb_address),
    .fb_data     (fb_data),
    .sprite_done (sprite_done),
    .busy        (busy),
    .clip_count  (clip_count)
  );

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;
  int wrCount = 0;
  int doneCount = 0;
  logic [16:0] lastWrAddr = '0;

  typedef struct {
    int x;
    int y;
    int c;
    bit l;
  } tup_t;

  tup_t        q[$];
  tup_t        t;
  bit          mReady = 0, mWren = 0, mLastRet = 0, mDone = 0, mActive = 0;
  bit          mPush, mPop, onScr;
  logic [16:0] mAddr = '0;
  logic [2:0]  mData = '0;
  logic [15:0] mClip = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int v, input int x, input int y, input int c, input int l, input int h);
    @(posedge clock_all);
    #1;
    in_valid  = (v != 0);
    in_x      = 9'(x);
    in_y      = 8'(y);
    in_colour = 3'(c);
    in_last   = (l != 0);
    fb_hold   = (h != 0);
  endtask

  task automatic sendTuple(input int x, input int y, input int c, input int l, input int h);
    bit rdy;
    bit accepted;
    accepted  = 1'b0;
    in_valid  = 1'b1;
    in_x      = 9'(x);
    in_y      = 8'(y);
    in_colour = 3'(c);
    in_last   = (l != 0);
    fb_hold   = (h != 0);
    for (int n = 0; n < 50 && !accepted; n++) begin
      rdy = in_ready;
      @(posedge clock_all);
      #1;
      if (rdy) accepted = 1'b1;
    end
    total++;
    if (!accepted) begin
      bad++;
      $display("[TB] FAIL handshake: tuple (%0d,%0d) got no accept, required accept within 50 cycles", x, y);
    end
  endtask

  task automatic waitSample(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_all);
      #2;
    end
  endtask

  // Reference model: a plain queue of accepted tuples retired one per unheld clock
  always @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      q.delete();
      mReady = 0; mWren = 0; mAddr = '0; mData = '0; mClip = '0;
      mLastRet = 0; mDone = 0; mActive = 0;
    end else begin
      mPush = in_valid && mReady;
      mPop  = (q.size() > 0) && !fb_hold;
      if (mDone && !mLastRet) mActive = (q.size() != 0);
      if (mPush) mActive = 1;
      mDone    = mLastRet;
      mLastRet = 0;
      mWren    = 0;
      if (mPop) begin
        t = q.pop_front();
        onScr = (t.x < 320) && (t.y < 240);
        if (onScr && !(TB_SKIP && t.c == 5)) begin
          mWren = 1;
          mAddr = 17'(t.y * 320 + t.x);
          mData = 3'(t.c);
        end else if (!onScr && mClip != 16'hFFFF) begin
          mClip = mClip + 16'd1;
        end
        mLastRet = t.l;
      end
      if (mPush) q.push_back('{x: int'(in_x), y: int'(in_y), c: int'(in_colour), l: in_last});
      mReady = (q.size() < DEPTH);
    end
  end

  always @(negedge clock_all) begin
    if (checkEn) begin
      checkOutput("in_ready", in_ready, mReady);
      checkOutput("fb_wren", fb_wren, mWren);
      checkOutput("fb_address", fb_address, mAddr);
      checkOutput("fb_data", fb_data, mData);
      checkOutput("sprite_done", sprite_done, mDone);
      checkOutput("busy", busy, (q.size() > 0) || mLastRet || mDone || mActive);
      checkOutput("clip_count", clip_count, mClip);
    end
  end

  always @(negedge clock_all) begin
    if (checkEn && fb_wren) begin
      wrCount++;
      lastWrAddr = fb_address;
    end
    if (checkEn && sprite_done) doneCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int w0, d0, readyDrop;
    #3 reset_all = 1'b0;
    #1 checkEn = 1'b1;
    waitSample(3);
    checkOutput("reset in_ready", in_ready, 0);
    @(negedge clock_all);
    reset_all = 1'b1;
    waitSample(1);
    checkOutput("release in_ready", in_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single tuple: write one cycle after the accept cycle, done the cycle after
    applyStimulus(1, 10, 2, 3, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitSample(1);
    checkOutput("single pre wren", fb_wren, 0);
    checkOutput("single busy", busy, 1);
    waitSample(1);
    checkOutput("single wren", fb_wren, 1);
    checkOutput("single addr", fb_address, 650);
    checkOutput("single data", fb_data, 3);
    waitSample(1);
    checkOutput("single done", sprite_done, 1);
    waitSample(1);
    checkOutput("single idle busy", busy, 0);
    checkOutput("single done low", sprite_done, 0);

    // Burst of 137 tuples on row 0 at full rate
    w0 = wrCount; d0 = doneCount; readyDrop = 0;
    for (int i = 0; i <= 136; i++) begin
      applyStimulus(1, i, 0, i % 8, (i == 136) ? 1 : 0, 0);
      if (!in_ready) readyDrop++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    waitSample(6);
    checkOutput("burst ready drops", readyDrop, 0);
    checkOutput("burst writes", wrCount - w0, 137);
    checkOutput("burst dones", doneCount - d0, 1);
    checkOutput("burst last addr", lastWrAddr, 136);

    // Held frame buffer: FIFO fills, then drains in order
    w0 = wrCount;
    waitSample(1);
    for (int i = 0; i < 4; i++) sendTuple(20 + i, 5, 1, 0, 1);
    waitSample(1);
    checkOutput("hold ready low", in_ready, 0);
    in_valid = 1'b1; in_x = 9'd24; in_last = 1'b0;
    waitSample(3);
    checkOutput("hold ready still low", in_ready, 0);
    checkOutput("hold no writes", wrCount - w0, 0);
    sendTuple(24, 5, 1, 0, 0);
    sendTuple(25, 5, 1, 1, 0);
    in_valid = 1'b0;
    waitSample(8);
    checkOutput("hold writes", wrCount - w0, 6);
    checkOutput("hold last addr", lastWrAddr, 1625);

    // Clipping at the screen edges
    w0 = wrCount; d0 = doneCount;
    sendTuple(319, 239, 6, 0, 0);
    sendTuple(320, 0, 6, 0, 0);
    sendTuple(0, 240, 6, 0, 0);
    sendTuple(511, 255, 6, 1, 0);
    in_valid = 1'b0;
    waitSample(8);
    checkOutput("clip writes", wrCount - w0, 1);
    checkOutput("clip addr", lastWrAddr, 76799);
    checkOutput("clip count", clip_count, 3);
    checkOutput("clip done", doneCount - d0, 1);

    // Transparent colour followed by a last tuple
    w0 = wrCount; d0 = doneCount;
    sendTuple(30, 3, 5, 0, 0);
    sendTuple(31, 3, 2, 1, 0);
    in_valid = 1'b0;
    waitSample(8);
    checkOutput("transp writes", wrCount - w0, TB_SKIP ? 1 : 2);
    checkOutput("transp done", doneCount - d0, 1);
    checkOutput("transp clip", clip_count, 3);
    checkOutput("transp addr", lastWrAddr, 991);

    // Reset with three buffered tuples and a last pending
    w0 = wrCount; d0 = doneCount;
    sendTuple(40, 7, 1, 0, 1);
    sendTuple(41, 7, 1, 0, 1);
    sendTuple(42, 7, 1, 1, 1);
    in_valid = 1'b0;
    waitSample(1);
    checkOutput("prereset busy", busy, 1);
    reset_all = 1'b0;
    #1;
    checkOutput("reset wren", fb_wren, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", sprite_done, 0);
    checkOutput("reset ready", in_ready, 0);
    checkOutput("reset clip", clip_count, 0);
    fb_hold = 1'b0;
    waitSample(2);
    @(negedge clock_all);
    reset_all = 1'b1;
    waitSample(8);
    checkOutput("postreset writes", wrCount - w0, 0);
    checkOutput("postreset dones", doneCount - d0, 0);
    checkOutput("postreset clip", clip_count, 0);
    checkOutput("postreset ready", in_ready, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 400), $urandom_range(0, 270),
                    $urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 1 : 0,
                    ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    waitSample(12);
    checkOutput("drain busy", busy, (q.size() > 0) || mLastRet || mDone || mActive);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Receiving end of the sprite-drawer pixel stream. Sprite drawers (HP bar, Pokémon, text) emit (x, y, colour) tuples one per clock.
- This block buffers the tuples, clips them to the 320x240 screen, and converts each to a linear frame-buffer address.
- Issues single-cycle writes to the VGA frame-buffer RAM port and reports sprite completion back to the game FSM.

Parameters:
- FIFO_DEPTH, 4, entries in the input buffer; power of two, minimum 2.
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- TRANSPARENT_COLOUR, 3'b101, colour code treated as see-through when TRANSPARENT_SKIP_EN is defined.

Ports:
- clock_all  in  1  system clock; all logic on posedge.
- reset_all  in  1  asynchronous, active-low reset.
- in_valid  in  1  a pixel tuple is presented.
- in_ready  out  1  block can accept a tuple this cycle.
- in_x  in  9  pixel x.
- in_y  in  8  pixel y.
- in_colour  in  3  pixel colour.
- in_last  in  1  marks the final tuple of a sprite.
- fb_hold  in  1  frame-buffer port is busy; no write may issue while high.
- fb_wren  out  1  frame-buffer write strobe.
- fb_address  out  17  linear address, y*SCREEN_W + x.
- fb_data  out  3  colour to write.
- sprite_done  out  1  one-cycle pulse after the last tuple is retired.
- busy  out  1  buffer non-empty or completion pending.
- clip_count  out  16  tuples discarded by clipping since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (reset_all=0, asynchronous): FIFO emptied; in_ready=0 while reset is asserted, then 1 on the first clock after release. All other outputs are 0; state returns to IDLE. Reset mid-sprite discards all buffered tuples and emits no sprite_done.
- Accept: a tuple is accepted on a posedge where in_valid=1 and in_ready=1.
  - in_ready is a registered output: 1 iff the FIFO count < FIFO_DEPTH.
  - in_ready has no combinational path from fb_hold or from a pop.
  - When the FIFO is full, a simultaneous pop does not allow a push in that cycle.
- Retire: on each posedge where the FIFO is non-empty and fb_hold=0, the head entry is popped.
  - If x < SCREEN_W and y < SCREEN_H: fb_wren=1 for the next cycle, with fb_address = (y<<8)+(y<<6)+x computed in 17 bits, and fb_data = colour.
  - Otherwise: fb_wren=0 and clip_count increments.
  - fb_address and fb_data hold their last values whenever fb_wren=0.
- Latency: into an empty FIFO with fb_hold=0, a tuple accepted at edge k produces fb_wren=1 in the cycle after edge k+1. Sustained throughput is 1 tuple/clock.
- fb_hold=1: no pop occurs and fb_wren=0. The FIFO fills, and in_ready falls once FIFO_DEPTH entries are held.
- FSM states:
  - IDLE: FIFO empty. The first accept moves to STREAM.
  - STREAM: retire entries. Retiring an entry with in_last=1 moves to DONE.
  - DONE: sprite_done=1 for exactly one cycle, then IDLE if the FIFO is empty, otherwise STREAM.
  - Tuples of the next sprite may be accepted during STREAM and DONE.
  - If two last-flagged entries retire back-to-back, each produces its own pulse; two consecutive pulses are legal.
- busy = (state != IDLE) or (FIFO non-empty).
- A clipped last tuple still produces sprite_done.

Optional Feature:
- TRANSPARENT_SKIP_EN defined: a retired in-screen entry whose colour equals TRANSPARENT_COLOUR is popped with fb_wren=0. It is not counted as clipped, and its in_last still ends the sprite.
- Not defined: every in-screen entry is written, whatever its colour.

Decomposition:
- Shared package holds:
  - constants SCREEN_W, SCREEN_H, FB_ADDR_W=17, X_W=9, Y_W=8, COLOUR_W=3;
  - the pixel tuple typedef {x, y, colour, last};
  - the FSM state enum {IDLE, STREAM, DONE}.
- One sub-module: fb_pixel_fifo. It is a synchronous FIFO with registered full/empty and count, stores the packed tuple, and its width comes from the package.

Test Plan:
- Single tuple x=10, y=2, colour=3'b011, last=1 with fb_hold=0 -> fb_wren=1 with fb_address=650, fb_data=3'b011 one cycle after the accept cycle; sprite_done pulses the following cycle; busy returns to 0.
- Burst of 137 tuples (x=0..136, y=0) at 1/clock, last on x=136 -> 137 consecutive write cycles with addresses 0..136; in_ready stays 1; one sprite_done.
- fb_hold=1 while presenting 6 tuples -> in_ready drops after 4 accepts, with no writes. Release fb_hold -> 4 writes, then the remaining 2 are accepted and written in order.
- Tuples (319,239), (320,0), (0,240), (511,255) -> only address 76799 is written; clip_count=3.
- With TRANSPARENT_SKIP_EN: tuples colour 3'b101 then 3'b010 (last) -> one write only; sprite_done still pulses; clip_count unchanged. Without the macro, both are written.
- Assert reset_all=0 with 3 entries buffered and a last pending -> outputs are 0 immediately; after release there are no writes, no sprite_done, clip_count=0, and in_ready=1.
